// File: rtl/pico_mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pico_mips_pkg : opcodes, instruction fields and program constants for pico_mips
// Rev 1.0
// ---------------------------------------------------------------------------
package pico_mips_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDI = 4'd1,
    OP_MULI = 4'd2,
    OP_LDSW = 4'd3,
    OP_OUT  = 4'd4,
    OP_BS1  = 4'd5,
    OP_BS0  = 4'd6,
    OP_J    = 4'd7
  } opcode_e;

  localparam int IW        = 18;
  localparam int PCW       = 5;
  localparam int ROM_DEPTH = 32;

  localparam int OP_HI  = 17;
  localparam int OP_LO  = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Q1.7 coefficients and affine offsets
  localparam logic [7:0] C075 = 8'h60;
  localparam logic [7:0] C05  = 8'h40;
  localparam logic [7:0] CM05 = 8'hC0;
  localparam logic [7:0] B1   = 8'd20;
  localparam logic [7:0] B2   = 8'hEC;

  function automatic logic [IW-1:0] mk(opcode_e op, logic [2:0] rd, logic [2:0] rs,
                                       logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pico_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pico_alu : combinational ADD / ADDI / Q1.7 fractional multiply
// Rev 1.0
// ---------------------------------------------------------------------------
module pico_alu #(
  parameter int n = 8
) (
  input  logic [3:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] imm,
  output logic [n-1:0] y
);
  import pico_mips_pkg::*;

  logic signed [2*n-1:0] w_prod;
  logic                  w_unused;

  assign w_prod   = $signed(a) * $signed(imm);
  // dropping the low n-1 bits is an arithmetic shift, i.e. floor toward -inf
  assign w_unused = &{1'b0, w_prod[2*n-1], w_prod[n-2:0]};

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_ADDI: y = a + imm;
      OP_MULI: y = w_prod[2*n-2:n-1];
      default: y = a;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pico_mips.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pico_mips : single-cycle 8-bit core running a fixed affine transform program
// Rev 1.0
// ---------------------------------------------------------------------------
module pico_mips #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw8,
  input  logic [n-1:0] sws,
  output logic [n-1:0] display
);
  import pico_mips_pkg::*;

  logic [PCW-1:0] r_pc;
  logic [PCW-1:0] w_pc_next;
  logic [IW-1:0]  w_instr;
  logic [3:0]     w_op;
  logic [2:0]     w_rd;
  logic [2:0]     w_rs;
  logic [7:0]     w_imm;
  logic [n-1:0]   r_regs [8];
  logic [n-1:0]   w_rd_val;
  logic [n-1:0]   w_rs_val;
  logic [n-1:0]   w_alu;
  logic [n-1:0]   w_wdata;
  logic           w_we;

  // Coefficient copies and clears are hoisted ahead of the last wait so that
  // x2 is ready in r3 and goes out on the cycle after sw8 is seen low.
  always_comb begin
    w_instr = mk(OP_J, 3'd0, 3'd0, 8'd0);
    case (r_pc)
      5'd0:  w_instr = mk(OP_BS0,  3'd0, 3'd0, 8'd0);
      5'd1:  w_instr = mk(OP_LDSW, 3'd1, 3'd0, 8'd0);
      5'd2:  w_instr = mk(OP_MULI, 3'd3, 3'd0, 8'd0);
      5'd3:  w_instr = mk(OP_MULI, 3'd4, 3'd0, 8'd0);
      5'd4:  w_instr = mk(OP_MULI, 3'd5, 3'd0, 8'd0);
      5'd5:  w_instr = mk(OP_MULI, 3'd6, 3'd0, 8'd0);
      5'd6:  w_instr = mk(OP_ADD,  3'd3, 3'd1, 8'd0);
      5'd7:  w_instr = mk(OP_ADD,  3'd4, 3'd1, 8'd0);
      5'd8:  w_instr = mk(OP_BS1,  3'd0, 3'd0, 8'd8);
      5'd9:  w_instr = mk(OP_BS0,  3'd0, 3'd0, 8'd9);
      5'd10: w_instr = mk(OP_LDSW, 3'd2, 3'd0, 8'd0);
      5'd11: w_instr = mk(OP_ADD,  3'd5, 3'd2, 8'd0);
      5'd12: w_instr = mk(OP_ADD,  3'd6, 3'd2, 8'd0);
      5'd13: w_instr = mk(OP_MULI, 3'd3, 3'd0, C075);
      5'd14: w_instr = mk(OP_MULI, 3'd4, 3'd0, CM05);
      5'd15: w_instr = mk(OP_MULI, 3'd5, 3'd0, C05);
      5'd16: w_instr = mk(OP_MULI, 3'd6, 3'd0, C075);
      5'd17: w_instr = mk(OP_ADD,  3'd3, 3'd5, 8'd0);
      5'd18: w_instr = mk(OP_ADD,  3'd4, 3'd6, 8'd0);
      5'd19: w_instr = mk(OP_ADDI, 3'd3, 3'd0, B1);
      5'd20: w_instr = mk(OP_ADDI, 3'd4, 3'd0, B2);
      5'd21: w_instr = mk(OP_BS1,  3'd0, 3'd0, 8'd21);
      5'd22: w_instr = mk(OP_OUT,  3'd0, 3'd3, 8'd0);
      5'd23: w_instr = mk(OP_BS0,  3'd0, 3'd0, 8'd23);
      5'd24: w_instr = mk(OP_OUT,  3'd0, 3'd4, 8'd0);
      5'd25: w_instr = mk(OP_BS1,  3'd0, 3'd0, 8'd25);
      5'd26: w_instr = mk(OP_J,    3'd0, 3'd0, 8'd0);
      default: w_instr = mk(OP_J,  3'd0, 3'd0, 8'd0);
    endcase
  end

  assign w_op  = w_instr[OP_HI:OP_LO];
  assign w_rd  = w_instr[RD_HI:RD_LO];
  assign w_rs  = w_instr[RS_HI:RS_LO];
  assign w_imm = w_instr[IMM_HI:IMM_LO];

  assign w_rd_val = (w_rd == 3'd0) ? '0 : r_regs[w_rd];
  assign w_rs_val = (w_rs == 3'd0) ? '0 : r_regs[w_rs];

  pico_alu #(.n(n)) u_alu (
    .op  (w_op),
    .a   (w_rd_val),
    .b   (w_rs_val),
    .imm (w_imm),
    .y   (w_alu)
  );

  assign w_wdata = (w_op == OP_LDSW) ? sws : w_alu;
  assign w_we    = (w_rd != 3'd0) &&
                   ((w_op == OP_ADD) || (w_op == OP_ADDI) ||
                    (w_op == OP_MULI) || (w_op == OP_LDSW));

  always_comb begin
    w_pc_next = r_pc + 5'd1;
    case (w_op)
      OP_BS1:  if (sw8)  w_pc_next = w_imm[4:0];
      OP_BS0:  if (!sw8) w_pc_next = w_imm[4:0];
      OP_J:    w_pc_next = w_imm[4:0];
      default: w_pc_next = r_pc + 5'd1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      display <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_we) r_regs[w_rd] <= w_wdata;
      if (w_op == OP_OUT) display <= w_rs_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pico_mips.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pico_mips : directed and random coordinate entries against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pico_mips;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw8;
  logic [7:0] sws;
  logic [7:0] display;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pico_mips #(.n(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw8     (sw8),
    .sws     (sws),
    .display (display)
  );

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (display === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, display, exp);
    end
  endtask

  // floor(v * c / 128) for Q1.7 coefficient c
  function automatic int fmul(input int v, input int c);
    return (v * c) >>> 7;
  endfunction

  function automatic logic [7:0] ref_x2(input logic [7:0] x, input logic [7:0] y);
    int xs, ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    return 8'(fmul(xs, 96) + fmul(ys, 64) + 20);
  endfunction

  function automatic logic [7:0] ref_y2(input logic [7:0] x, input logic [7:0] y);
    int xs, ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    return 8'(fmul(xs, -64) + fmul(ys, 96) - 20);
  endfunction

  task automatic press(input logic [7:0] v);
    sws = v;
    sw8 = 1'b1;
    tick(2);
    sw8 = 1'b0;
  endtask

  task automatic transaction(input string tag, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ex, ey;
    ex = ref_x2(x, y);
    ey = ref_y2(x, y);
    press(x);
    tick(10);
    press(y);
    tick(14);
    check({tag, "_x2"}, ex);
    tick(5);
    check({tag, "_x2_hold"}, ex);
    press(8'h00);
    tick(6);
    check({tag, "_y2"}, ey);
    tick(4);
  endtask

  initial begin
    reset = 1'b0;
    sw8   = 1'b0;
    sws   = 8'h00;
    #2 reset = 1'b1;
    tick(2);
    check("reset_state", 8'h00);
    reset = 1'b0;
    tick(5);
    check("idle_after_reset", 8'h00);

    transaction("xy_2_2", 8'd2, 8'd2);
    transaction("xy_0_0", 8'd0, 8'd0);
    transaction("xy_100_100", 8'd100, 8'd100);
    transaction("xy_neg", 8'h80, 8'h7F);

    // reset while waiting for y1: display must clear without a clock edge
    press(8'd5);
    tick(3);
    #2 reset = 1'b1;
    #1 check("reset_async", 8'h00);
    tick(1);
    reset = 1'b0;
    tick(3);
    check("reset_mid_hold", 8'h00);
    transaction("after_reset", 8'd2, 8'd2);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] rx, ry;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      transaction($sformatf("rand%0d", i), rx, ry);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
